// File: rtl/seq_div16by8.sv
// Sequential restoring divider: unsigned DVD_W-bit dividend / DVS_W-bit divisor -> quotient, remainder.
// Latency: out_valid rises DVD_W edges after the accepting edge; on the accepting edge itself when divisor is zero.
// Backpressure: in_ready is low outside IDLE; results are held in DONE until out_ready. DIV_SELFCHECK_EN adds a q*d+r==n check.
module seq_div16by8 #(
    parameter int DVD_W = 16,
    parameter int DVS_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_zero,
    output logic             chk_err
);

    localparam int CNT_W = $clog2(DVD_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DVD_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [DVD_W-1:0] dvd_sh;     // dividend, consumed MSB first by shifting left
    logic [DVS_W-1:0] dvs_q;
    logic [DVD_W-1:0] q_work;
    logic [DVS_W-1:0] rem_work;   // partial remainder, always < divisor between steps
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             last_step;
    logic [DVS_W:0]   part;       // one extra bit so the shifted-in value never loses its carry
    logic             ge;
    logic [DVS_W-1:0] rem_nxt;
    logic [DVD_W-1:0] q_nxt;

    assign accept    = in_valid && in_ready;
    assign last_step = (state == CALC) && (cnt == LAST);

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        part    = {rem_work, dvd_sh[DVD_W-1]};
        ge      = (part >= {1'b0, dvs_q});
        // when ge holds the true difference is below the divisor, so DVS_W bits suffice
        rem_nxt = ge ? (part[DVS_W-1:0] - dvs_q) : part[DVS_W-1:0];
        q_nxt   = {q_work[DVD_W-2:0], ge};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake flags registered from the next state; in_ready stays low until the first edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
        end
    end

    // Operand latch, iteration datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_sh    <= '0;
            dvs_q     <= '0;
            q_work    <= '0;
            rem_work  <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvd_sh   <= dividend;
                        dvs_q    <= divisor;
                        q_work   <= '0;
                        rem_work <= '0;
                        cnt      <= '0;
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend[DVS_W-1:0];
                            div_zero  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    dvd_sh   <= dvd_sh << 1;
                    q_work   <= q_nxt;
                    rem_work <= rem_nxt;
                    cnt      <= cnt + CNT_W'(1);
                    // results only move on the final step, so no partial value is ever exposed
                    if (cnt == LAST) begin
                        quotient  <= q_nxt;
                        remainder <= rem_nxt;
                        div_zero  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DIV_SELFCHECK_EN
    localparam int PW = DVD_W + DVS_W;

    logic [DVD_W-1:0] dvd_orig;
    logic [PW-1:0]    recon;

    assign recon = PW'(q_nxt) * PW'(dvs_q) + PW'(rem_nxt);

    // Keep the untouched dividend for the reconstruction check
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_orig <= '0;
        end else if (accept) begin
            dvd_orig <= dividend;
        end
    end

    // Flag a mismatch on entry to DONE; clear when the result is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err <= 1'b0;
        end else if (last_step) begin
            chk_err <= (recon != PW'(dvd_orig));
        end else if ((state == DONE) && out_ready) begin
            chk_err <= 1'b0;
        end
    end
`else
    logic unused_last;
    assign unused_last = last_step;
    assign chk_err     = 1'b0;
`endif

endmodule
